// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared constants, command record and FSM encoding for the
//            shift issue stage.
// Revision : 1.0
// ============================================================================
package shift_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] din;
        logic [SHW-1:0]   shamt;
        logic             lr;
        logic             al;
    } shift_cmd_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_P1   = 2'd1;
    localparam logic [1:0] S_P2   = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : shift_cmd_fifo
// Brief    : DEPTH-entry FIFO of shift commands with full/empty flags.
// Revision : 1.0
// ============================================================================
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  shift_cmd_t push_data,
    input  logic       pop,
    output shift_cmd_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    shift_cmd_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

endmodule : shift_cmd_fifo
`default_nettype wire

// File: rtl/shift_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_ctrl
// Brief    : Queues shift commands, drives an external combinational barrel
//            shifter one command at a time and registers its result.
//            Define SHIFT_ROT_EN to build rotate-left from two shifter passes.
// Revision : 1.0
// ============================================================================
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_din,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_lr,
    input  logic             in_al,
    output logic [WIDTH-1:0] sh_din,
    output logic [SHW-1:0]   sh_shamt,
    output logic             sh_lr,
    output logic             sh_al,
    input  logic [WIDTH-1:0] sh_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_state;
    shift_cmd_t       r_cmd;
    logic [WIDTH-1:0] r_res;
    shift_cmd_t       w_push_cmd;
    shift_cmd_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_pop;

    assign in_ready   = ~w_full;
    assign w_in_fire  = in_valid & in_ready;
    assign w_push_cmd = '{din: in_din, shamt: in_shamt, lr: in_lr, al: in_al};
    assign out_valid  = (r_state == S_OUT);
    assign out_data   = r_res;
    assign w_out_fire = out_valid & out_ready;
    assign w_pop      = ~w_empty & ((r_state == S_IDLE) | w_out_fire);

    shift_cmd_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_in_fire),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

`ifdef SHIFT_ROT_EN
    logic w_rot_2pass;
    assign w_rot_2pass = r_cmd.lr & r_cmd.al & (r_cmd.shamt != '0);
`endif

    // Shifter inputs are idle-zero outside the two working states; A_L only
    // matters for right shifts, so it is forced low on any left pass.
    always_comb begin
        sh_din   = '0;
        sh_shamt = '0;
        sh_lr    = 1'b0;
        sh_al    = 1'b0;
        case (r_state)
            S_P1: begin
                sh_din   = r_cmd.din;
                sh_shamt = r_cmd.shamt;
                sh_lr    = r_cmd.lr;
                sh_al    = r_cmd.lr ? 1'b0 : r_cmd.al;
            end
`ifdef SHIFT_ROT_EN
            S_P2: begin
                sh_din   = r_cmd.din;
                sh_shamt = SHW'(WIDTH - int'(r_cmd.shamt));
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= w_head;
                        r_state <= S_P1;
                    end
                end
                S_P1: begin
                    r_res <= sh_dout;
`ifdef SHIFT_ROT_EN
                    r_state <= w_rot_2pass ? S_P2 : S_OUT;
`else
                    r_state <= S_OUT;
`endif
                end
`ifdef SHIFT_ROT_EN
                S_P2: begin
                    r_res   <= r_res | sh_dout;
                    r_state <= S_OUT;
                end
`endif
                S_OUT: begin
                    if (w_out_fire) begin
                        if (w_pop) begin
                            r_cmd   <= w_head;
                            r_state <= S_P1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule : shift_issue_ctrl
`default_nettype wire

// File: tb/tb_shift_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_issue_ctrl
// Brief    : Scoreboard bench for shift_issue_ctrl with a behavioural shifter.
// Revision : 1.0
// ============================================================================
module tb_shift_issue_ctrl;
    import shift_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_din;
    logic [SHW-1:0]   in_shamt;
    logic             in_lr;
    logic             in_al;
    logic [WIDTH-1:0] sh_din;
    logic [SHW-1:0]   sh_shamt;
    logic             sh_lr;
    logic             sh_al;
    logic [WIDTH-1:0] sh_dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_din(in_din),
        .in_shamt(in_shamt), .in_lr(in_lr), .in_al(in_al),
        .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
        .sh_dout(sh_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Combinational barrel shifter standing in for the real one.
    always_comb begin
        if (sh_lr)      sh_dout = sh_din << sh_shamt;
        else if (sh_al) sh_dout = $signed(sh_din) >>> sh_shamt;
        else            sh_dout = sh_din >> sh_shamt;
    end

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int s,
                                                input logic lr, input logic al);
        int v;
        int m;
        m = (1 << WIDTH) - 1;
        v = int'(d);
        if (lr) begin
`ifdef SHIFT_ROT_EN
            if (al) return WIDTH'(((v << s) | (v >> (WIDTH - s))) & m);
`endif
            return WIDTH'((v << s) & m);
        end
        if (al && v >= (1 << (WIDTH - 1))) v = v - (1 << WIDTH);
        return WIDTH'((v >>> s) & m);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard producer: every accepted command queues its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            exp_q.push_back(model(in_din, int'(in_shamt), in_lr, in_al));
    end

    // Monitor: compares each delivered result and checks hold-stability under backpressure.
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!out_valid || out_data !== prev_data) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b data=%0h expected valid=1 data=%0h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: data=%0h with no expected result pending", out_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL result: got %0h expected %0h at %0t", out_data, e, $time);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input logic lr, input logic al);
        bit ok = 1'b0;
        in_valid = 1'b1; in_din = d; in_shamt = s; in_lr = lr; in_al = al;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic lat_test(input string name, input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                            input logic lr, input logic al, input logic [WIDTH-1:0] exp_d, input int exp_lat);
        int lat = 1;
        bit seen = 1'b0;
        send(d, s, lr, al);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_data"}, 32'(out_data), 32'(exp_d));
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] rdin;
        bit               found;
        bit               bp_done;
        d0 = 8'b11010101;
        rdin = 8'h3C;
        rst = 1'b1; in_valid = 1'b0; in_din = '0; in_shamt = '0; in_lr = 1'b0; in_al = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sh_bus", 32'({sh_din, sh_shamt, sh_lr, sh_al}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed shifts and latencies.
        lat_test("lsr1", d0, 3'd1, 1'b0, 1'b0, 8'b01101010, 3);
        lat_test("asr2", d0, 3'd2, 1'b0, 1'b1, 8'b11110101, 3);
        lat_test("lsl3", d0, 3'd3, 1'b1, 1'b0, 8'b10101000, 3);
`ifdef SHIFT_ROT_EN
        lat_test("rol3", d0, 3'd3, 1'b1, 1'b1, 8'b10101110, 4);
`else
        lat_test("rol3", d0, 3'd3, 1'b1, 1'b1, 8'b10101000, 3);
`endif
        lat_test("rol0", d0, 3'd0, 1'b1, 1'b1, 8'b11010101, 3);
        lat_test("asr7_pos", 8'h75, 3'd7, 1'b0, 1'b1, 8'h00, 3);

        // Fill: 4 queued plus 1 held in the output stage.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(WIDTH'(8'h11 * (k + 1)), SHW'(k), 1'b0, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_din = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_hold_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Randomised traffic with random output backpressure.
        bp_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(WIDTH'($urandom), SHW'($urandom), 1'($urandom), 1'($urandom));
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset while the rotate command is mid-flight with three queued behind it.
        out_ready = 1'b0;
        send(d0, 3'd1, 1'b0, 1'b0);
        send(rdin, 3'd3, 1'b1, 1'b1);
        send(8'h81, 3'd1, 1'b0, 1'b1);
        send(8'h42, 3'd2, 1'b1, 1'b0);
        send(8'h99, 3'd4, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
`ifdef SHIFT_ROT_EN
            found = (sh_din == rdin) && !sh_lr && (sh_shamt == SHW'(WIDTH - 3));
`else
            found = (sh_din == rdin) && sh_lr && (sh_shamt == 3'd3);
`endif
        end
        check("reset_point_found", 32'(found), 32'd1);
        check("reset_queued_count", 32'(exp_q.size()), 32'd4);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_sh_bus", 32'({sh_din, sh_shamt, sh_lr, sh_al}), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end

        // Block still functional after reset.
        @(posedge clk); #1;
        lat_test("post_rst_lsl1", 8'h81, 3'd1, 1'b1, 1'b0, 8'h02, 3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_issue_ctrl
`default_nettype wire
